// File: rtl/vga_timing.sv
// Free-running VGA raster timing generator: counters and blank/sync flags,
// all registered from the same next-state decode so they share one cycle.
module vga_timing #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter bit H_SYNC_POL = 1'b1,
  parameter bit V_SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hblnk,
  output logic        vblnk,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  // Bounds kept at 12 bits so a sync window ending exactly at 2048 still compares correctly.
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] r_hcount, r_vcount;
  logic        r_hblnk, r_vblnk, r_hsync, r_vsync, r_frame_start;

  logic [10:0] w_hcount_nxt, w_vcount_nxt;
  logic [11:0] w_h_ext, w_v_ext;
  logic        w_hblnk_nxt, w_vblnk_nxt, w_hsync_nxt, w_vsync_nxt, w_frame_start_nxt;

  always_comb begin
    w_hcount_nxt = r_hcount + 11'd1;
    w_vcount_nxt = r_vcount;
    if (r_hcount == H_LAST) begin
      w_hcount_nxt = 11'd0;
      w_vcount_nxt = (r_vcount == V_LAST) ? 11'd0 : r_vcount + 11'd1;
    end
  end

  // Flags decode the counter values that will be loaded, so they land together.
  always_comb begin
    w_h_ext           = {1'b0, w_hcount_nxt};
    w_v_ext           = {1'b0, w_vcount_nxt};
    w_hblnk_nxt       = (w_h_ext >= H_ACT_END);
    w_vblnk_nxt       = (w_v_ext >= V_ACT_END);
    w_hsync_nxt       = ((w_h_ext >= H_SYNC_BEG) && (w_h_ext < H_SYNC_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    w_vsync_nxt       = ((w_v_ext >= V_SYNC_BEG) && (w_v_ext < V_SYNC_END)) ? V_SYNC_POL : ~V_SYNC_POL;
    w_frame_start_nxt = (w_hcount_nxt == 11'd0) && (w_vcount_nxt == 11'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcount      <= 11'd0;
      r_vcount      <= 11'd0;
      r_hblnk       <= 1'b0;
      r_vblnk       <= 1'b0;
      r_hsync       <= ~H_SYNC_POL;
      r_vsync       <= ~V_SYNC_POL;
      r_frame_start <= 1'b0;
    end else begin
      r_hcount      <= w_hcount_nxt;
      r_vcount      <= w_vcount_nxt;
      r_hblnk       <= w_hblnk_nxt;
      r_vblnk       <= w_vblnk_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hblnk       = r_hblnk;
  assign vblnk       = r_vblnk;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;

endmodule
